// File: rtl/rgb888_to_565_byte_packer.sv
// RGB888 -> RGB565 encoder with optional 2x2 Bayer dither, emitting each pixel as two bytes.
// First byte valid 1 cycle after pixel accept; holds bytes and drops pix_ready while byte_ready is low.
module rgb888_to_565_byte_packer #(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 32,
  parameter int DITHER_EN = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  input  logic       pix_sof,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] byte_data,
  output logic       byte_last
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t        state, state_nxt;
  logic          accept;
  logic [XW-1:0] x, x_nxt, cur_x;
  logic [YW-1:0] y, y_nxt, cur_y;
  logic [1:0]    d;
  logic [2:0]    rb_off, g_off;
  logic [7:0]    r_sat, g_sat, b_sat;
  logic [15:0]   word_q, word_nxt;
  logic          last_q, pix_last;

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [2:0] off);
    logic [8:0] s;
    s = {1'b0, c} + {6'b0, off};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign accept = pix_valid & pix_ready;

  // Encode using the coordinates of the pixel being offered; sof forces (0,0).
  always_comb begin
    cur_x = pix_sof ? '0 : x;
    cur_y = pix_sof ? '0 : y;
    case ({cur_y[0], cur_x[0]})
      2'b00:   d = 2'd0;
      2'b01:   d = 2'd2;
      2'b10:   d = 2'd3;
      default: d = 2'd1;
    endcase
    if (DITHER_EN == 0) d = 2'd0;
    rb_off   = {d, 1'b0};
    g_off    = {1'b0, d};
    r_sat    = sat_add(pix_r, rb_off);
    g_sat    = sat_add(pix_g, g_off);
    b_sat    = sat_add(pix_b, rb_off);
    word_nxt = {r_sat[7:3], g_sat[7:2], b_sat[7:3]};
    pix_last = (cur_x == X_MAX) && (cur_y == Y_MAX);
  end

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (accept) begin
      if (cur_x == X_MAX) begin
        x_nxt = '0;
        y_nxt = (cur_y == Y_MAX) ? '0 : cur_y + YW'(1);
      end else begin
        x_nxt = cur_x + XW'(1);
        y_nxt = cur_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      word_q <= '0;
      last_q <= 1'b0;
    end else begin
      x <= x_nxt;
      y <= y_nxt;
      if (accept) begin
        word_q <= word_nxt;
        last_q <= pix_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FIRST;
      FIRST:   if (byte_ready) state_nxt = SECOND;
      SECOND:  if (byte_ready) state_nxt = accept ? FIRST : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte outputs come straight from registered state, so they hold while stalled.
  always_comb begin
    pix_ready  = (state == IDLE) | ((state == SECOND) & byte_ready);
    byte_valid = (state != IDLE);
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    case (state)
      FIRST:  byte_data = (MSB_FIRST != 0) ? word_q[15:8] : word_q[7:0];
      SECOND: begin
        byte_data = (MSB_FIRST != 0) ? word_q[7:0] : word_q[15:8];
        byte_last = last_q;
      end
      default: ;
    endcase
  end

endmodule
